// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main control FSM.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter with enable and synchronous active-low clear.
module instret_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Clear wins over enable; the count wraps naturally.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_main_control.sv
// Moore-style main control FSM for the multicycle RV32I datapath.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ResultSrc,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  state_e state_q, state_d;

  logic mem_req_c, ir_write_c, pc_update_c, branch_c, reg_write_c, mem_write_c, illegal_c;
  logic retire;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_update_c = 1'b0;
    branch_c    = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    illegal_c   = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    ResultSrc   = RES_ALUOUT;
    unique case (state_q)
      StFetch: begin
        mem_req_c   = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALU;
        ir_write_c  = mem_ready;
        pc_update_c = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = StMemAdr;
          OP_R:              state_d = StExecR;
          OP_I:              state_d = StExecI;
          OP_BEQ:            state_d = StBeq;
          OP_JAL:            state_d = StJal;
          default: begin
            state_d   = StFetch;
            illegal_c = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc   = RES_MEMDATA;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StBeq: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_SUB;
        branch_c = 1'b1;
        state_d  = StFetch;
      end
      StJal: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pc_update_c = 1'b1;
        state_d     = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Side-effecting strobes are held off while reset is asserted.
  assign mem_req       = rst_n & mem_req_c;
  assign IRWrite       = rst_n & ir_write_c;
  assign PCUpdate      = rst_n & pc_update_c;
  assign Branch        = rst_n & branch_c;
  assign RegWrite      = rst_n & reg_write_c;
  assign MemWrite      = rst_n & mem_write_c;
  assign illegal_instr = rst_n & illegal_c;

  // An instruction retires in its last cycle; stores retire once memory accepts them.
  assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
                  ((state_q == StMemWrite) && mem_ready);

  instret_counter #(
    .Width(INSTRET_W)
  ) u_instret (
    .clk  (clk),
    .clr_n(rst_n),
    .en   (retire),
    .count(instret)
  );

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Moore-style control FSM for the multicycle RV32I datapath, sitting upstream of `ALU_control`. It steps each instruction through fetch/decode/execute/memory/writeback and drives all datapath enables and mux selects. It generates the 2-bit `ALUOp` that `ALU_control` consumes, and handshakes with a single instruction/data memory port through a `mem_req`/`mem_ready` pair. It also keeps a retired-instruction counter.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `op`  in  7  opcode, `instr[6:0]`, from the instruction register; stable after `IRWrite`.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access requested.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  load the instruction register and OldPC.
- `PCUpdate`  out  1  unconditional PC write.
- `Branch`  out  1  PC write qualified by ALU zero (beq).
- `RegWrite`  out  1  register-file write.
- `MemWrite`  out  1  memory write strobe.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- `ALUSrcB`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = decode funct3/funct7 (to `ALU_control`).
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `illegal_instr`  out  1  one-cycle pulse: unsupported opcode decoded.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Any output not listed for a state is 0.
- **FETCH**
  - Outputs: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` = `PCUpdate` = `mem_ready`.
  - Leaves to DECODE only when `mem_ready`=1; otherwise holds in FETCH.
- **DECODE** (computes branch target)
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00.
  - Next state by `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with `illegal_instr`=1 for this cycle.
- **MEMADR**
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - Next: MEMREAD if `op[5]`=0, MEMWRITE if `op[5]`=1.
- **MEMREAD**
  - Outputs: `mem_req`=1, `AdrSrc`=1, `ResultSrc`=00.
  - Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**
  - Outputs: `ResultSrc`=01, `RegWrite`=1.
  - Next: FETCH.
- **MEMWRITE**
  - Outputs: `mem_req`=1, `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1 (held until `mem_ready`).
  - Goes to FETCH on `mem_ready`.
- **EXECR**
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - Next: ALUWB.
- **EXECI**
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - Next: ALUWB.
- **ALUWB**
  - Outputs: `ResultSrc`=00, `RegWrite`=1.
  - Next: FETCH.
- **BEQ**
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1.
  - Next: FETCH.
- **JAL** (PC ← branch target, ALU computes OldPC+4)
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1.
  - Next: ALUWB.
- **instret** increments by 1 on these cycles:
  - leaving MEMWB, ALUWB or BEQ;
  - MEMWRITE with `mem_ready`=1.
  - Wraps modulo 2^INSTRET_W.
  - Illegal instructions are not counted.

## Timing
- `state` and `instret` are registered; all outputs decode combinationally from `state`. `IRWrite`/`PCUpdate` in FETCH and `instret` increment additionally depend on `mem_ready`.
- Reset: a rising edge with `rst_n`=0 sets state to FETCH and `instret` to 0. While `rst_n`=0, `mem_req`, `IRWrite`, `PCUpdate`, `RegWrite`, `MemWrite`, `Branch` and `illegal_instr` are forced to 0.
- Reset mid-instruction abandons the instruction, with no retire and no write.
- Latency with zero-wait memory (`mem_ready` high):
  - R/I-type and beq/jal: 4 cycles (beq 3).
  - lw: 5 cycles.
  - sw: 4 cycles.
- Each wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- `mem_ready` is ignored in states where `mem_req`=0.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum (4-bit encoding);
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - the SrcA/SrcB/ResultSrc encodings.
- One sub-module: `instret_counter` (enable and synchronous active-low clear).

## Test plan
- Reset with `mem_ready`=1, then `op`=0110011 → states FETCH, DECODE, EXECR (`ALUOp`=10), ALUWB (`RegWrite`=1), FETCH; `instret`=1.
- `op`=0000011, `mem_ready` low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with `AdrSrc`=1; then MEMWB with `ResultSrc`=01; `instret`+1.
- `op`=0100011 with immediate ready → `MemWrite`=1 for exactly 1 cycle; `RegWrite` never asserted; `instret`+1.
- `op`=1100011 → BEQ: `ALUOp`=01, `Branch`=1, `ALUSrcA`=10, `ALUSrcB`=00; back to FETCH after 3 cycles total.
- `op`=1111111 → `illegal_instr` pulses 1 cycle in DECODE; next state FETCH; `instret` unchanged.
- `rst_n` low during MEMWRITE → no `MemWrite` during reset; FETCH and `instret`=0 after the edge. Also preload `instret`=2^32−1, retire one instruction → `instret`=0.
